// File: rtl/sonar_tx_frame_pkg.sv
// Shared types, constants and helpers for the sonar frame sequencer.
// SONAR_TX_CHECKSUM_EN adds a checksum character before the terminator.
package sonar_pkg;

  localparam int unsigned ESTADO_W = 4;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned CHAR_W   = 7;

`ifdef SONAR_TX_CHECKSUM_EN
  localparam int unsigned ULTIMO = 8;
`else
  localparam int unsigned ULTIMO = 7;
`endif

  // Codes double as the debug state display.
  typedef enum logic [ESTADO_W-1:0] {
    ST_INICIAL   = 4'd0,
    ST_CARREGA   = 4'd1,
    ST_TRANSMITE = 4'd2,
    ST_ESPERA    = 4'd3,
    ST_PROXIMO   = 4'd4,
    ST_FINAL     = 4'd5,
    ST_ABORTA    = 4'd6
  } estado_t;

  localparam logic [CHAR_W-1:0] ASCII_ZERO      = 7'h30;
  localparam logic [CHAR_W-1:0] ASCII_INTERROG  = 7'h3F;
  localparam logic [CHAR_W-1:0] ASCII_VIRGULA   = 7'h2C;
  localparam logic [CHAR_W-1:0] ASCII_CERQUILHA = 7'h23;

  typedef struct packed {
    logic [BCD_W-1:0] angulo;
    logic [BCD_W-1:0] distancia;
  } snapshot_t;

  function automatic logic [CHAR_W-1:0] bcd_to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? ASCII_ZERO + CHAR_W'(d) : ASCII_INTERROG;
  endfunction

endpackage

// File: rtl/sonar_tx_frame_if.sv
// Start/done handshake between the frame sequencer and the UART transmitter.
interface sonar_tx_frame_if;
  logic       tx_partida;
  logic [6:0] tx_dado;
  logic       tx_pronto;

  modport master (output tx_partida, output tx_dado, input tx_pronto);
  modport slave  (input tx_partida, input tx_dado, output tx_pronto);
endinterface

// File: rtl/sonar_tx_frame_mux.sv
// Character selector: frame index + snapshot -> ASCII code.
// SONAR_TX_CHECKSUM_EN inserts a hex checksum character before the terminator.
module sonar_tx_mux
  import sonar_pkg::*;
#(
  parameter logic [7:0] SEPARADOR  = 8'h2C,
  parameter logic [7:0] TERMINADOR = 8'h23
) (
  input  logic [IDX_W-1:0]  indice,
  input  snapshot_t         snapshot,
  output logic [CHAR_W-1:0] dado
);

  logic [CHAR_W-1:0] car [7];

  always_comb begin
    car[0] = bcd_to_ascii(snapshot.angulo[11:8]);
    car[1] = bcd_to_ascii(snapshot.angulo[7:4]);
    car[2] = bcd_to_ascii(snapshot.angulo[3:0]);
    car[3] = SEPARADOR[CHAR_W-1:0];
    car[4] = bcd_to_ascii(snapshot.distancia[11:8]);
    car[5] = bcd_to_ascii(snapshot.distancia[7:4]);
    car[6] = bcd_to_ascii(snapshot.distancia[3:0]);
  end

`ifdef SONAR_TX_CHECKSUM_EN
  // Only the low nibble of the running sum matters for mod 16.
  logic [3:0]        soma;
  logic [CHAR_W-1:0] checksum;

  always_comb begin
    soma = 4'd0;
    for (int i = 0; i < 7; i++) soma = soma + car[i][3:0];
    checksum = (soma <= 4'd9) ? 7'h30 + CHAR_W'(soma) : 7'h37 + CHAR_W'(soma);
  end
`endif

  always_comb begin
    dado = '0;
    if (indice < IDX_W'(7))
      dado = car[indice[2:0]];
    else if (indice == IDX_W'(ULTIMO))
      dado = TERMINADOR[CHAR_W-1:0];
`ifdef SONAR_TX_CHECKSUM_EN
    else if (indice == IDX_W'(7))
      dado = checksum;
`endif
  end

endmodule

// File: rtl/sonar_tx_frame.sv
// Sends "AAA,DDD#" one character per transmitter start/done transaction.
// SONAR_TX_CHECKSUM_EN adds a checksum character before '#'.
module sonar_tx_frame
  import sonar_pkg::*;
#(
  parameter logic [7:0]  SEPARADOR      = {1'b0, ASCII_VIRGULA},
  parameter logic [7:0]  TERMINADOR     = {1'b0, ASCII_CERQUILHA},
  parameter int unsigned TIMEOUT_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [BCD_W-1:0]    angulo,
  input  logic [BCD_W-1:0]    distancia,
  sonar_tx_frame_if.master    tx,
  output logic                ocupado,
  output logic                pronto,
  output logic                erro,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int unsigned TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LIM =
    TIMER_W'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);

  estado_t              estado, estado_n;
  logic [IDX_W-1:0]     indice, indice_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  snapshot_t            snap, snap_n;
  logic                 partida;
  logic [CHAR_W-1:0]    dado;

  // State, counters, snapshot and outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= ST_INICIAL;
      indice    <= '0;
      timer     <= '0;
      snap      <= '0;
      partida   <= 1'b0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      db_estado <= '0;
    end else begin
      estado    <= estado_n;
      indice    <= indice_n;
      timer     <= timer_n;
      snap      <= snap_n;
      partida   <= (estado_n == ST_TRANSMITE);
      ocupado   <= (estado_n != ST_INICIAL);
      pronto    <= (estado_n == ST_FINAL);
      erro      <= (estado_n == ST_ABORTA);
      db_estado <= estado_n;
    end
  end

  always_comb begin
    estado_n = estado;
    indice_n = indice;
    timer_n  = timer;
    snap_n   = snap;
    case (estado)
      ST_INICIAL:   if (iniciar) estado_n = ST_CARREGA;
      ST_CARREGA: begin
        snap_n   = '{angulo: angulo, distancia: distancia};
        indice_n = '0;
        estado_n = ST_TRANSMITE;
      end
      ST_TRANSMITE: begin
        timer_n  = '0;
        estado_n = ST_ESPERA;
      end
      ST_ESPERA: begin
        timer_n = timer + TIMER_W'(1);
        // A done pulse in the timeout cycle still counts as success.
        if (tx.tx_pronto)
          estado_n = ST_PROXIMO;
        else if ((TIMEOUT_CICLOS != 0) && (timer == TIMER_LIM))
          estado_n = ST_ABORTA;
      end
      ST_PROXIMO: begin
        if (indice == IDX_W'(ULTIMO)) begin
          estado_n = ST_FINAL;
        end else begin
          indice_n = indice + IDX_W'(1);
          estado_n = ST_TRANSMITE;
        end
      end
      ST_FINAL:     estado_n = ST_INICIAL;
      ST_ABORTA:    estado_n = ST_INICIAL;
      default:      estado_n = ST_INICIAL;
    endcase
  end

  sonar_tx_mux #(
    .SEPARADOR  (SEPARADOR),
    .TERMINADOR (TERMINADOR)
  ) u_mux (
    .indice   (indice),
    .snapshot (snap),
    .dado     (dado)
  );

  assign tx.tx_partida = partida;
  assign tx.tx_dado    = ocupado ? dado : '0;

endmodule

// File: tb/tb_sonar_tx_frame.sv
// Randomized bench for sonar_tx_frame with a frame-level reference model.
// Build with SONAR_TX_CHECKSUM_EN to exercise the checksum character.
module tb_sonar_tx_frame;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic [11:0] angulo = '0;
  logic [11:0] distancia = '0;
  logic        ocupado, pronto, erro;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] last_frame[$];

  sonar_tx_frame_if txif();

  sonar_tx_frame #(.TIMEOUT_CICLOS(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .angulo    (angulo),
    .distancia (distancia),
    .tx        (txif),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] digit_char(input int n);
    return (n < 10) ? 7'(48 + n) : 7'(63);
  endfunction

  // Expected frame text derived from the character rules.
  task automatic build_frame(input logic [11:0] a, input logic [11:0] d,
                             output logic [6:0] q[$]);
    int sum;
    q = {};
    for (int i = 2; i >= 0; i--) q.push_back(digit_char(int'((a >> (4*i)) & 12'hF)));
    q.push_back(7'd44);
    for (int i = 2; i >= 0; i--) q.push_back(digit_char(int'((d >> (4*i)) & 12'hF)));
`ifdef SONAR_TX_CHECKSUM_EN
    sum = 0;
    foreach (q[i]) sum += int'(q[i]);
    sum = sum % 16;
    q.push_back((sum < 10) ? 7'(48 + sum) : 7'(55 + sum));
`else
    sum = 0;
`endif
    q.push_back(7'd35);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_partida"}, int'(txif.tx_partida), 0);
    check_eq({tag, "_dado"}, int'(txif.tx_dado), 0);
    check_eq({tag, "_ocupado"}, int'(ocupado), 0);
    check_eq({tag, "_pronto"}, int'(pronto), 0);
    check_eq({tag, "_erro"}, int'(erro), 0);
    check_eq({tag, "_estado"}, int'(db_estado), 0);
  endtask

  // mute_char: 1-based character never answered; rst_char: character whose wait gets a reset.
  task automatic run_frame(input logic [11:0] a, input logic [11:0] d, input int lat,
                           input int mute_char, input int rst_char, input bit disturb);
    logic [6:0] exp_q[$];
    logic [6:0] got_q[$];
    logic [6:0] cur;
    int partidas, prontos, erros, countdown, cyc;
    bit done, was_reset;
    partidas = 0; prontos = 0; erros = 0; countdown = 0; cyc = 0;
    done = 0; was_reset = 0; cur = '0;
    build_frame(a, d, exp_q);
    angulo = a; distancia = d; iniciar = 1'b1;
    step(); cyc = 1;
    iniciar = 1'b0;
    check_eq("carrega_state", int'(db_estado), 1);
    check_eq("carrega_ocupado", int'(ocupado), 1);
    while (!done && cyc < 2000) begin
      step(); cyc++;
      txif.tx_pronto = 1'b0;
      iniciar = 1'b0;
      if (txif.tx_partida) begin
        partidas++;
        cur = txif.tx_dado;
        got_q.push_back(cur);
        if (partidas == 1) check_eq("first_latency", cyc, 2);
        countdown = (partidas == mute_char) ? 0 : lat;
        if (disturb && partidas < exp_q.size()) begin
          iniciar   = 1'b1;
          angulo    = 12'($urandom);
          distancia = 12'($urandom);
        end
      end else if (rst_char != 0 && partidas == rst_char && countdown == lat - 2) begin
        reset = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        step();
        reset = 1'b1;
        was_reset = 1;
        done = 1;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          check_eq("dado_stable", int'(txif.tx_dado), int'(cur));
          txif.tx_pronto = 1'b1;
        end
      end
      if (pronto) prontos++;
      if (erro) erros++;
      if (pronto || erro) done = 1;
    end
    txif.tx_pronto = 1'b0;
    iniciar = 1'b0;
    if (!done) check_eq("frame_budget", cyc, -1);
    last_frame = got_q;
    if (!was_reset) begin
      check_eq("n_partida", partidas, (mute_char != 0) ? mute_char : exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check_eq($sformatf("char%0d", i), int'(got_q[i]), int'(exp_q[i]));
      check_eq("n_pronto", prontos, (mute_char != 0) ? 0 : 1);
      check_eq("n_erro", erros, (mute_char != 0) ? 1 : 0);
      step();
      check_eq("end_ocupado", int'(ocupado), 0);
      check_eq("end_estado", int'(db_estado), 0);
      check_eq("end_pronto", int'(pronto), 0);
      check_eq("end_erro", int'(erro), 0);
    end
  endtask

  initial begin
    logic [11:0] ra, rd;
    txif.tx_pronto = 1'b0;
    step(); step();
    check_idle_zero("reset");
    reset = 1'b1;
    step();
    check_idle_zero("idle");

    // Stray done pulse while idle must not move the FSM.
    txif.tx_pronto = 1'b1;
    step();
    txif.tx_pronto = 1'b0;
    step();
    check_eq("stray_estado", int'(db_estado), 0);
    check_eq("stray_partida", int'(txif.tx_partida), 0);

    run_frame(12'h045, 12'h123, 10, 0, 0, 0);
`ifdef SONAR_TX_CHECKSUM_EN
    check_eq("checksum_char", int'(last_frame[7]), 'h42);
`endif
    run_frame(12'h0A9, 12'h123, 10, 0, 0, 0);
    check_eq("invalid_digit", int'(last_frame[1]), 'h3F);

    run_frame(12'h180, 12'h999, 10, 3, 0, 0);
    check_eq("timeout_partidas", last_frame.size(), 3);

    run_frame(12'h270, 12'h456, 10, 0, 5, 0);
    step();
    check_idle_zero("post_reset");
    run_frame(12'h314, 12'h078, 10, 0, 0, 0);

    run_frame(12'h555, 12'h321, 7, 0, 0, 1);

    for (int k = 0; k < 6; k++) begin
      ra = {4'($urandom_range(0, 12)), 4'($urandom_range(0, 12)), 4'($urandom_range(0, 12))};
      rd = {4'($urandom_range(0, 12)), 4'($urandom_range(0, 12)), 4'($urandom_range(0, 12))};
      run_frame(ra, rd, int'($urandom_range(1, 19)), 0, 0, k[0]);
    end
    run_frame(12'h999, 12'h000, 19, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
